// File: rtl/tx_eof_async_fifo.sv
`timescale 1ns/1ps
// Dual-clock 512x36 first-word-fall-through FIFO with Gray-pointer crossing and EOF toggle synchronisers.
// Flags and counts are registered; far-side moves reach the flags within 3-4 clocks. Writes when full and pops when empty are dropped.
module tx_eof_async_fifo #(
  parameter int DEPTH     = 512,
  parameter int AF_THRESH = 256,
  parameter int AE_THRESH = 128
) (
  input  logic        rst,
  input  logic        rd_clk,
  input  logic        wr_clk,
  input  logic [35:0] wr_di,
  input  logic        wr_en,
  output logic        wr_full,
  output logic        wr_almost_full,
  output logic [9:0]  wr_count,
  output logic        wr_eof_poped,
  input  logic        rd_en,
  output logic [35:0] rd_do,
  output logic        rd_empty,
  output logic        rd_almost_empty,
  output logic [9:0]  rd_count,
  output logic        rd_eof_rdy
);

  localparam logic [9:0] FULL_LVL = 10'(DEPTH);
  localparam logic [9:0] AF_LVL   = 10'(AF_THRESH);
  localparam logic [9:0] AE_LVL   = 10'(AE_THRESH);

  function automatic logic [9:0] bin2gray(input logic [9:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [9:0] gray2bin(input logic [9:0] g);
    logic [9:0] b;
    b[9] = g[9];
    for (int i = 8; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [35:0] mem [DEPTH];

  logic       wr_rst_meta;
  logic       wr_rst;
  logic [9:0] wr_ptr;
  logic [9:0] wr_gray;
  logic [9:0] rd_gray_m;
  logic [9:0] rd_gray_s;
  logic       wr_eof_tgl;
  logic [2:0] pop_tgl_s;
  logic       wr_push;
  logic [9:0] wr_ptr_nxt;
  logic [9:0] wr_cnt_nxt;

  logic [9:0] rd_ptr;
  logic [9:0] rd_gray;
  logic [9:0] wr_gray_m;
  logic [9:0] wr_gray_s;
  logic       rd_eof_tgl;
  logic [2:0] eof_tgl_s;
  logic       rd_pop;
  logic       rd_eof_pop;
  logic       wr_eof;
  logic [9:0] rd_ptr_nxt;
  logic [9:0] rd_cnt_nxt;

  // ---------------- write domain ----------------
  always_ff @(posedge wr_clk) begin
    wr_rst_meta <= rst;
    wr_rst      <= wr_rst_meta;
  end

  assign wr_push    = wr_en && !wr_full && !wr_rst;
  assign wr_ptr_nxt = wr_ptr + {9'd0, wr_push};
  // Stale synced read pointer can only overstate occupancy, so full never drops early.
  assign wr_cnt_nxt = wr_ptr_nxt - gray2bin(rd_gray_s);

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_ptr         <= '0;
      wr_gray        <= '0;
      rd_gray_m      <= '0;
      rd_gray_s      <= '0;
      wr_eof_tgl     <= 1'b0;
      pop_tgl_s      <= '0;
      wr_count       <= '0;
      wr_full        <= 1'b0;
      wr_almost_full <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      wr_gray        <= bin2gray(wr_ptr_nxt);
      rd_gray_m      <= rd_gray;
      rd_gray_s      <= rd_gray_m;
      pop_tgl_s      <= {pop_tgl_s[1:0], rd_eof_tgl};
      wr_count       <= wr_cnt_nxt;
      wr_full        <= (wr_cnt_nxt == FULL_LVL);
      wr_almost_full <= (wr_cnt_nxt >= AF_LVL);
      if (wr_push && wr_di[34]) wr_eof_tgl <= ~wr_eof_tgl;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_push) mem[wr_ptr[8:0]] <= wr_di;
  end

  assign wr_eof_poped = pop_tgl_s[2] ^ pop_tgl_s[1];

  // ---------------- read domain ----------------
  assign rd_pop     = rd_en && !rd_empty;
  assign rd_eof_pop = rd_pop && rd_do[34];
  assign rd_ptr_nxt = rd_ptr + {9'd0, rd_pop};
  assign rd_cnt_nxt = gray2bin(wr_gray_s) - rd_ptr_nxt;
  assign wr_eof     = eof_tgl_s[2] ^ eof_tgl_s[1];

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_ptr          <= '0;
      rd_gray         <= '0;
      wr_gray_m       <= '0;
      wr_gray_s       <= '0;
      rd_eof_tgl      <= 1'b0;
      eof_tgl_s       <= '0;
      rd_count        <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_eof_rdy      <= 1'b0;
    end else begin
      rd_ptr          <= rd_ptr_nxt;
      rd_gray         <= bin2gray(rd_ptr_nxt);
      wr_gray_m       <= wr_gray;
      wr_gray_s       <= wr_gray_m;
      eof_tgl_s       <= {eof_tgl_s[1:0], wr_eof_tgl};
      rd_count        <= rd_cnt_nxt;
      rd_empty        <= (rd_cnt_nxt == '0);
      rd_almost_empty <= (rd_cnt_nxt <= AE_LVL);
      if (rd_eof_pop) rd_eof_tgl <= ~rd_eof_tgl;
      if (wr_eof) rd_eof_rdy <= 1'b1;
      else if (rd_eof_pop) rd_eof_rdy <= 1'b0;
    end
  end

  // Head register re-reads every cycle, so a slot written while empty has settled before rd_empty drops.
  always_ff @(posedge rd_clk) begin
    rd_do <= mem[rd_ptr_nxt[8:0]];
  end

endmodule

// File: tb/tb_tx_eof_async_fifo.sv
`timescale 1ns/1ps
// Scoreboard bench for tx_eof_async_fifo with wr_clk at 100 MHz and rd_clk at 62.5 MHz.
module tb_tx_eof_async_fifo;

  logic        rst    = 1'b1;
  logic        rd_clk = 1'b0;
  logic        wr_clk = 1'b0;
  logic [35:0] wr_di  = '0;
  logic        wr_en  = 1'b0;
  logic        rd_en  = 1'b0;
  logic        wr_full, wr_almost_full, wr_eof_poped;
  logic        rd_empty, rd_almost_empty, rd_eof_rdy;
  logic [9:0]  wr_count, rd_count;
  logic [35:0] rd_do;

  int n_chk  = 0;
  int n_fail = 0;
  int n, pulses, first, st_sent, st_got, wc, rc;
  logic        w_en, r_en;
  logic [35:0] w_d;
  logic [63:0] r_e;
  logic [35:0] sb [$];

  tx_eof_async_fifo dut (
    .rst            (rst),
    .rd_clk         (rd_clk),
    .wr_clk         (wr_clk),
    .wr_di          (wr_di),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_count       (wr_count),
    .wr_eof_poped   (wr_eof_poped),
    .rd_en          (rd_en),
    .rd_do          (rd_do),
    .rd_empty       (rd_empty),
    .rd_almost_empty(rd_almost_empty),
    .rd_count       (rd_count),
    .rd_eof_rdy     (rd_eof_rdy)
  );

  always #5 wr_clk = ~wr_clk;
  always #8 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rd_wait(input int c);
    repeat (c) @(negedge rd_clk);
  endtask

  task automatic wr_wait(input int c);
    repeat (c) @(negedge wr_clk);
  endtask

  task automatic wr_word(input logic [35:0] d);
    @(negedge wr_clk);
    wr_en = 1'b1;
    wr_di = d;
    if (!wr_full) sb.push_back(d);
    @(posedge wr_clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic rd_pop(input string tag);
    logic [63:0] e;
    int w = 0;
    @(negedge rd_clk);
    while (rd_empty && w < 8) begin
      @(negedge rd_clk);
      w++;
    end
    chk({tag, "_avail"}, 64'(rd_empty), 64'd0);
    if (!rd_empty) begin
      e = '1;
      if (sb.size() > 0) e = 64'(sb.pop_front());
      chk(tag, 64'(rd_do), e);
      rd_en = 1'b1;
      @(posedge rd_clk);
      #1 rd_en = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_empty"}, 64'(rd_empty), 64'd1);
    chk({tag, "_rd_ae"}, 64'(rd_almost_empty), 64'd1);
    chk({tag, "_wr_full"}, 64'(wr_full), 64'd0);
    chk({tag, "_wr_af"}, 64'(wr_almost_full), 64'd0);
    chk({tag, "_wr_count"}, 64'(wr_count), 64'd0);
    chk({tag, "_rd_count"}, 64'(rd_count), 64'd0);
    chk({tag, "_eof_rdy"}, 64'(rd_eof_rdy), 64'd0);
    chk({tag, "_eof_poped"}, 64'(wr_eof_poped), 64'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog sim time exceeded checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then release and let the write-side reset synchroniser drain.
    rd_wait(5);
    chk_reset_vals("rst_hold");
    @(negedge rd_clk) rst = 1'b0;
    wr_wait(4);
    chk_reset_vals("rst_rel");

    // Three plain words in order.
    for (int i = 1; i <= 3; i++) wr_word(36'(i));
    n = 0;
    while (rd_empty && n < 5) begin
      @(negedge rd_clk);
      n++;
    end
    chk("empty_fall", 64'(rd_empty), 64'd0);
    chk("fwft_head", 64'(rd_do), 64'h1);
    for (int i = 0; i < 3; i++) rd_pop("ord3");
    chk("empty_after3", 64'(rd_empty), 64'd1);

    // Fill to full with no reads.
    for (int i = 0; i < 512; i++) begin
      wr_word({4'b1000 | 4'(i & 3), 32'hA500_0000 + 32'(i)});
      if (i == 254) chk("af_255", 64'(wr_almost_full), 64'd0);
      if (i == 255) begin
        chk("af_256", 64'(wr_almost_full), 64'd1);
        chk("cnt_256", 64'(wr_count), 64'd256);
      end
      if (i == 510) chk("full_511", 64'(wr_full), 64'd0);
    end
    chk("full_512", 64'(wr_full), 64'd1);
    chk("cnt_512", 64'(wr_count), 64'd512);
    chk("af_512", 64'(wr_almost_full), 64'd1);
    wr_word(36'h0_DEAD_BEEF);
    chk("ovf_cnt", 64'(wr_count), 64'd512);
    chk("ovf_full", 64'(wr_full), 64'd1);

    // Drain from full.
    rd_wait(6);
    chk("rd_cnt_full", 64'(rd_count), 64'd512);
    chk("rd_ae_full", 64'(rd_almost_empty), 64'd0);
    for (int k = 1; k <= 512; k++) begin
      rd_pop("drain");
      chk("drain_cnt", 64'(rd_count), 64'(512 - k));
      chk("drain_ae", 64'(rd_almost_empty), 64'((512 - k) <= 128));
      if (k == 1) begin
        n = 0;
        while (wr_full && n < 5) begin
          @(negedge wr_clk);
          n++;
        end
        chk("full_fall", 64'(wr_full), 64'd0);
      end
    end
    chk("drain_empty", 64'(rd_empty), 64'd1);
    rd_en = 1'b1;
    rd_wait(4);
    rd_en = 1'b0;
    chk("uflow_cnt", 64'(rd_count), 64'd0);
    chk("uflow_empty", 64'(rd_empty), 64'd1);
    chk("uflow_ae", 64'(rd_almost_empty), 64'd1);
    wr_wait(5);
    chk("wr_cnt_zero", 64'(wr_count), 64'd0);
    chk("wr_af_zero", 64'(wr_almost_full), 64'd0);

    // Single EOF word through both toggle synchronisers.
    chk("eof_idle", 64'(rd_eof_rdy), 64'd0);
    wr_word(36'h4_0000_00AA);
    n = 0;
    while (!rd_eof_rdy && n < 4) begin
      @(negedge rd_clk);
      n++;
    end
    chk("eof_rdy_set", 64'(rd_eof_rdy), 64'd1);
    rd_pop("eof_word");
    chk("eof_rdy_clr", 64'(rd_eof_rdy), 64'd0);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge wr_clk);
      if (wr_eof_poped) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    chk("poped_pulses", 64'(pulses), 64'd1);
    chk("poped_in_time", 64'(first >= 1 && first <= 4), 64'd1);

    // Random streaming across several pointer wraps.
    st_sent = 0;
    st_got  = 0;
    wc      = 0;
    rc      = 0;
    fork
      begin : writer
        while (st_sent < 2000 && wc < 40000) begin
          @(negedge wr_clk);
          wc++;
          w_en = ($urandom_range(0, 3) != 0);
          w_d  = {2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), 16'(st_sent), 16'($urandom)};
          if (w_en && !wr_full) begin
            sb.push_back(w_d);
            st_sent++;
          end
          wr_en = w_en;
          wr_di = w_d;
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
      end
      begin : reader
        while (st_got < 2000 && rc < 30000) begin
          @(negedge rd_clk);
          rc++;
          r_en = ($urandom_range(0, 1) == 1);
          if (r_en && !rd_empty) begin
            r_e = '1;
            if (sb.size() > 0) r_e = 64'(sb.pop_front());
            chk("stream_data", 64'(rd_do), r_e);
            st_got++;
          end
          rd_en = r_en;
        end
        @(negedge rd_clk);
        rd_en = 1'b0;
      end
    join
    chk("stream_sent", 64'(st_sent), 64'd2000);
    chk("stream_got", 64'(st_got), 64'd2000);
    rd_wait(6);
    chk("stream_empty", 64'(rd_empty), 64'd1);

    // Reset with the FIFO half full and an EOF pending.
    wr_word(36'h4_0000_0001);
    for (int i = 1; i < 256; i++) wr_word(36'h1_0000_0000 | 36'(i));
    n = 0;
    while (!rd_eof_rdy && n < 8) begin
      @(negedge rd_clk);
      n++;
    end
    chk("half_eof", 64'(rd_eof_rdy), 64'd1);
    chk("half_af", 64'(wr_almost_full), 64'd1);
    @(negedge rd_clk) rst = 1'b1;
    sb.delete();
    rd_wait(4);
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    rd_wait(10);
    chk_reset_vals("post_rst");
    wr_word(36'h0_0000_0123);
    rd_pop("post_rst_data");
    chk("post_rst_empty", 64'(rd_empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_eof_async_fifo.md
TX_EOF_ASYNC_FIFO -- requirements
Module: tx_eof_async_fifo

Interface
REQ-001 Parameters: DEPTH, 512, storage depth in words; AF_THRESH, 256, almost-full occupancy threshold; AE_THRESH, 128, almost-empty occupancy threshold.
REQ-002 Reset rst is synchronous and active-high; the clock is rd_clk.
REQ-003 rst  in  1  synchronous active-high reset, sampled on rd_clk, resynchronised into wr_clk.
REQ-004 rd_clk  in  1  read-side clock.
REQ-005 wr_clk  in  1  write-side clock, asynchronous to rd_clk.
REQ-006 wr_di  in  36  write data; bit 34 is the end-of-frame (EOF) marker, bits 35:32 are sideband.
REQ-007 wr_en  in  1  push wr_di on wr_clk.
REQ-008 wr_full  out  1  FIFO full (wr_clk domain).
REQ-009 wr_almost_full  out  1  occupancy >= AF_THRESH (wr_clk domain).
REQ-010 wr_count  out  10  write-side occupancy, 0..512.
REQ-011 wr_eof_poped  out  1  one-wr_clk pulse when an EOF word was popped.
REQ-012 rd_en  in  1  pop the head word on rd_clk.
REQ-013 rd_do  out  36  head word, first-word-fall-through.
REQ-014 rd_empty  out  1  FIFO empty (rd_clk domain).
REQ-015 rd_almost_empty  out  1  occupancy <= AE_THRESH (rd_clk domain).
REQ-016 rd_count  out  10  read-side occupancy, 0..512.
REQ-017 rd_eof_rdy  out  1  at least one EOF word written and not yet popped.

Function
REQ-018 Storage SHALL be a 512x36 dual-clock memory with 10-bit binary pointers, Gray-coded before crossing, with a 2-flop synchroniser per direction.
REQ-019 wr_en with wr_full=1 SHALL be ignored; the pointer and data are unchanged.
REQ-020 rd_en with rd_empty=1 SHALL be ignored; there is no underflow.
REQ-021 FWFT: while rd_empty=0, rd_do SHALL present the oldest word; rd_en=1 SHALL pop it, and the next word SHALL appear on rd_do after the same edge, or rd_empty SHALL assert.
REQ-022 Flag timing: wr_full SHALL assert on the wr_clk edge of the 512th write. rd_empty SHALL assert on the rd_clk edge of the last pop.
REQ-023 Deassertion of wr_full and rd_empty SHALL take at most 4 cycles of the observing clock after the opposite-side event (pessimistic, never early).
REQ-024 wr_count and wr_almost_full SHALL be computed from the write pointer and the synchronised read pointer. rd_count and rd_almost_empty SHALL be computed from the read pointer and the synchronised write pointer. Both SHALL use modulo-1024 subtraction, and the results SHALL be registered.
REQ-025 The pointer wrap from 1023 to 0 SHALL be seamless, with no flag glitches.
REQ-026 EOF write sync: each accepted write with wr_di[34]=1 (wr_en and not wr_full) SHALL toggle a wr_clk flag. The flag SHALL pass a 2-flop synchroniser into rd_clk, and an edge detect SHALL give a one-rd_clk pulse wr_eof, 2-3 rd_clk cycles later.
REQ-027 EOF pop sync: each accepted pop with rd_do[34]=1 SHALL be carried by the same toggle synchroniser into wr_clk, producing a one-cycle wr_eof_poped pulse 2-3 wr_clk cycles later.
REQ-028 Two EOF events closer than 3 destination clocks SHALL be allowed to merge into one pulse; the caller guarantees spacing.
REQ-029 rd_eof_rdy SHALL be a rd_clk register. It SHALL set to 1 on a wr_eof pulse, and otherwise clear to 0 on rd_en && rd_do[34] && !rd_empty. On a simultaneous set and clear, set SHALL win.

Reset
REQ-030 On rst, the following SHALL be cleared: pointers, synchronisers and toggle flags in both domains.
REQ-031 Reset values SHALL be: rd_empty=1, rd_almost_empty=1, wr_full=0, wr_almost_full=0, wr_count=0, rd_count=0, rd_eof_rdy=0, wr_eof_poped=0, rd_do don't-care.
REQ-032 rst SHALL be held for at least 3 cycles of the slower clock; wr_en and rd_en SHALL be ignored during reset.
REQ-033 A reset asserted mid-transfer SHALL discard all contents, including any pending EOF pulses.

Verification
REQ-034 After reset, write 0x0_0000_0001..0x0_0000_0003 with bit 34 clear -> rd_empty falls within 4 rd_clk cycles; rd_do=0x000000001; three pops return 1,2,3 in order; rd_empty=1 afterwards.
REQ-035 Write 512 words without reading -> wr_full=1 on the 512th write, wr_count=512, wr_almost_full=1 from the 256th write; a 513th write is ignored, and reading returns exactly 512 words.
REQ-036 From full, pop words -> rd_almost_empty=1 once rd_count<=128; rd_count counts down to 0; rd_en on empty causes no change.
REQ-037 Write one word with wr_di[34]=1 (value 0x4_0000_00AA) -> rd_eof_rdy=1 within 3 rd_clk cycles. Popping it clears rd_eof_rdy and produces exactly one wr_eof_poped pulse within 3 wr_clk cycles.
REQ-038 Run wr_clk at 100 MHz and rd_clk at 62.5 MHz, streaming 2000 words with continuous random wr_en/rd_en -> data order is preserved, there are no lost or duplicated words, and the pointers wrap cleanly.
REQ-039 Assert rst with the FIFO half full and EOF pending -> all outputs return to their reset values, and rd_eof_rdy=0.
